// File: rtl/lms_adaptive_fir.sv
`default_nettype none
// ============================================================================
// Module   : lms_adaptive_fir
// Brief    : Single-MAC LMS adaptive FIR with saturating in-place weight
//            update. Define LMS_LEAKAGE_EN to enable leaky weight update.
// Revision : 1.0 - initial release
// ============================================================================
module lms_adaptive_fir #(
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int TAPS       = 128,
    parameter int FRAC_W     = 15,
    parameter int LEAK_SHIFT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_sample,
    input  logic              err_valid,
    output logic              err_ready,
    input  logic [DATA_W-1:0] error_in,
    input  logic [DATA_W-1:0] u_in,
    input  logic              adapt_en,
    output logic              busy,
    output logic              overrun
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int MP_W   = DATA_W + COEF_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int WIDE_W = ACC_W + DATA_W + 2;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_MAC    = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_SCALE  = 3'd3;
    localparam logic [2:0] c_ST_UPDATE = 3'd4;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [WIDE_W-1:0] v);
        logic signed [WIDE_W-1:0] lim_hi;
        logic signed [WIDE_W-1:0] lim_lo;
        lim_hi = '0;
        lim_hi[DATA_W-2:0] = '1;
        lim_lo = ~lim_hi;
        if (v > lim_hi)      return lim_hi[DATA_W-1:0];
        else if (v < lim_lo) return lim_lo[DATA_W-1:0];
        else                 return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [WIDE_W-1:0] v);
        logic signed [WIDE_W-1:0] lim_hi;
        logic signed [WIDE_W-1:0] lim_lo;
        lim_hi = '0;
        lim_hi[COEF_W-2:0] = '1;
        lim_lo = ~lim_hi;
        if (v > lim_hi)      return lim_hi[COEF_W-1:0];
        else if (v < lim_lo) return lim_lo[COEF_W-1:0];
        else                 return v[COEF_W-1:0];
    endfunction

    logic [2:0]               r_state;
    logic [2:0]               w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [COEF_W-1:0] r_w [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_err;
    logic signed [DATA_W-1:0] r_mu;
    logic signed [DATA_W-1:0] r_e_mu;
    logic                     r_adapt;
    logic                     r_in_ready;
    logic                     r_err_ready;
    logic                     r_busy;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_out_sample;
    logic                     r_overrun;

    logic                     w_last;
    logic signed [DATA_W-1:0] w_x_k;
    logic signed [COEF_W-1:0] w_w_k;
    logic signed [MP_W-1:0]   w_mac_prod;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [DATA_W-1:0] w_out_sat;
    logic signed [PROD_W-1:0] w_emu_prod;
    logic signed [DATA_W-1:0] w_emu_sat;
    logic signed [PROD_W-1:0] w_upd_prod;
    logic signed [WIDE_W-1:0] w_upd_sum;

    assign w_last     = (r_idx == IDX_W'(TAPS - 1));
    assign w_x_k      = r_x[r_idx];
    assign w_w_k      = r_w[r_idx];
    assign w_mac_prod = MP_W'(w_w_k) * MP_W'(w_x_k);
    assign w_acc_sum  = r_acc + ACC_W'(w_mac_prod);
    assign w_out_sat  = sat_data(WIDE_W'(w_acc_sum >>> FRAC_W));
    assign w_emu_prod = PROD_W'(r_err) * PROD_W'(r_mu);
    assign w_emu_sat  = sat_data(WIDE_W'(w_emu_prod >>> FRAC_W));
    assign w_upd_prod = PROD_W'(r_e_mu) * PROD_W'(w_x_k);

`ifdef LMS_LEAKAGE_EN
    assign w_upd_sum = WIDE_W'(w_w_k) - WIDE_W'(w_w_k >>> LEAK_SHIFT)
                     + WIDE_W'(w_upd_prod >>> FRAC_W);
`else
    // LEAK_SHIFT only matters for the leaky build; kept for a stable interface.
    logic w_unused_leak;
    assign w_unused_leak = (LEAK_SHIFT > 0);
    assign w_upd_sum     = WIDE_W'(w_w_k) + WIDE_W'(w_upd_prod >>> FRAC_W);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (in_valid)  w_state_next = c_ST_MAC;
            c_ST_MAC:    if (w_last)    w_state_next = c_ST_WAIT;
            c_ST_WAIT:   if (err_valid) w_state_next = c_ST_SCALE;
            c_ST_SCALE:  w_state_next = r_adapt ? c_ST_UPDATE : c_ST_IDLE;
            c_ST_UPDATE: if (w_last)    w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_acc        <= '0;
            r_err        <= '0;
            r_mu         <= '0;
            r_e_mu       <= '0;
            r_adapt      <= 1'b0;
            r_in_ready   <= 1'b1;
            r_err_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sample <= '0;
            r_overrun    <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
                r_w[k] <= '0;
            end
        end else begin
            // Handshake flags are decoded from the next state so they line up with it.
            r_in_ready  <= (w_state_next == c_ST_IDLE);
            r_err_ready <= (w_state_next == c_ST_WAIT);
            r_busy      <= (w_state_next != c_ST_IDLE);
            r_out_valid <= 1'b0;
            if (in_valid && !r_in_ready) r_overrun <= 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_x[0] <= $signed(in_sample);
                        for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                c_ST_MAC: begin
                    r_acc <= w_acc_sum;
                    r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_out_sample <= w_out_sat;
                        r_out_valid  <= 1'b1;
                    end
                end
                c_ST_WAIT: begin
                    if (err_valid) begin
                        r_err   <= $signed(error_in);
                        r_mu    <= $signed(u_in);
                        r_adapt <= adapt_en;
                    end
                end
                c_ST_SCALE: begin
                    r_e_mu <= w_emu_sat;
                    r_idx  <= '0;
                end
                c_ST_UPDATE: begin
                    r_w[r_idx] <= sat_coef(w_upd_sum);
                    r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign err_ready  = r_err_ready;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_sample = r_out_sample;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lms_adaptive_fir.sv
`default_nettype none
// ============================================================================
// Module   : tb_lms_adaptive_fir
// Brief    : Scoreboard bench for lms_adaptive_fir (TAPS=4) against an
//            arithmetic LMS model; honours LMS_LEAKAGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lms_adaptive_fir;

    localparam int DATA_W     = 16;
    localparam int COEF_W     = 16;
    localparam int TAPS       = 4;
    localparam int FRAC_W     = 15;
    localparam int LEAK_SHIFT = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sample;
    logic              out_valid;
    logic [DATA_W-1:0] out_sample;
    logic              err_valid;
    logic              err_ready;
    logic [DATA_W-1:0] error_in;
    logic [DATA_W-1:0] u_in;
    logic              adapt_en;
    logic              busy;
    logic              overrun;

    lms_adaptive_fir #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
        .FRAC_W(FRAC_W), .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .out_valid(out_valid), .out_sample(out_sample),
        .err_valid(err_valid), .err_ready(err_ready),
        .error_in(error_in), .u_in(u_in), .adapt_en(adapt_en),
        .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint last_out;
    longint exp_q[$];
    longint mx[TAPS];
    longint mw[TAPS];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int n);
        longint hi;
        hi = (longint'(1) <<< (n - 1)) - 1;
        if (v > hi)      return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic longint s16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: y = sat(sum(w*x) >> F); w += sat-clamped (sat(e*mu >> F) * x) >> F
    task automatic model_sample(input logic [15:0] xs);
        longint acc;
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = s16(xs);
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += mw[k] * mx[k];
        exp_q.push_back(sat(acc >>> FRAC_W, DATA_W));
    endtask

    task automatic model_error(input logic [15:0] e, input logic [15:0] mu, input bit adapt);
        longint emu, d;
        emu = sat((s16(e) * s16(mu)) >>> FRAC_W, DATA_W);
        if (adapt) begin
            for (int k = 0; k < TAPS; k++) begin
                d = (emu * mx[k]) >>> FRAC_W;
`ifdef LMS_LEAKAGE_EN
                mw[k] = sat(mw[k] - (mw[k] >>> LEAK_SHIFT) + d, COEF_W);
`else
                mw[k] = sat(mw[k] + d, COEF_W);
`endif
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            mx[k] = 0;
            mw[k] = 0;
        end
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got %0d, expected no output", s16(out_sample));
            end else begin
                check("out_sample", s16(out_sample), exp_q.pop_front());
            end
        end
    end

    // One sample + error transaction; called and returns on a falling edge.
    task automatic run_iter(input logic [15:0] xs, input logic [15:0] e, input logic [15:0] mu,
                            input bit adapt, input bit pulse, input int rst_at);
        int n;
        bit got;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", n, -1);
            return;
        end
        in_valid  = 1'b1;
        in_sample = xs;
        model_sample(xs);
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) in_valid = 1'b0;
            if (pulse && n == 2) begin
                in_valid  = 1'b1;
                in_sample = 16'($urandom);
            end
            if (pulse && n == 3) in_valid = 1'b0;
            got = out_valid;
        end
        check("out_latency", n, TAPS + 1);
        last_out = s16(out_sample);
        check("err_ready_with_out", err_ready, 1);
        check("in_ready_low_in_wait", in_ready, 0);
        err_valid = 1'b1;
        error_in  = e;
        u_in      = mu;
        adapt_en  = adapt;
        model_error(e, mu, adapt);
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) err_valid = 1'b0;
            if (rst_at != 0 && n == rst_at) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("midrst_in_ready", in_ready, 1);
                check("midrst_busy", busy, 0);
                check("midrst_err_ready", err_ready, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            got = in_ready;
        end
        check("idle_latency", n, adapt ? TAPS + 2 : 2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        err_valid = 1'b0;
        error_in  = '0;
        u_in      = '0;
        adapt_en  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_ready", err_ready, 0);
        check("rst_out_sample", s16(out_sample), 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);

        // Zero weights: output 0, full adaptive turnaround.
        run_iter(16'd1000, 16'h1234, 16'h0000, 1'b1, 1'b0, 0);
        check("zero_weight_out", last_out, 0);

        // Adapt, then reset in the middle of a weight update.
        run_iter(16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 0);
        run_iter(16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 3);
        check("midrst_overrun", overrun, 0);

        run_iter(16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0, 0);
        check("post_reset_weights_zero", last_out, 0);
        run_iter(16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        check("w0_4096_out", last_out, 2048);
        run_iter(16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        check("freeze_out", last_out, 2048);
`ifdef LMS_LEAKAGE_EN
        run_iter(16'h4000, 16'h0000, 16'h4000, 1'b1, 1'b0, 0);
        run_iter(16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        check("leak_w0_3840_out", last_out, 1920);
`endif

        // Overrun: a stray sample during MAC is dropped.
        check("overrun_before", overrun, 0);
        run_iter(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h7FFF)), 1'b1, 1'b1, 0);
        check("overrun_sticky", overrun, 1);

        // Saturation
        do_reset();
        repeat (20) run_iter(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 0);
        check("sat_out", last_out, 32767);
        run_iter(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        run_iter(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        run_iter(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) begin
            run_iter((i == 0) ? 16'h4000 : 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 0);
            check("sat_weight_probe", last_out, 16383);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            run_iter(16'($urandom), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
